risc8_fetch: RTL and testbench
==============================

Name: risc8_fetch

Overview:
Instruction fetch and prefetch stage sitting directly upstream of the risc8 control/datapath.
- Streams bytes from the byte-wide program ROM into a small byte FIFO.
- Presents the opcode byte plus the next three bytes (immediate window) to control.
- Retires 1–4 bytes per accepted instruction, using the isize that control decodes from the opcode.
- Handles PC redirects (jump/branch/call/ret/reti) by flushing the buffer and any in-flight read.

Parameters:
ADDR_W, 16, width of program (ROM) byte address and PC.
DEPTH, 8, prefetch FIFO depth in bytes; power of two, ≥4.
RESET_PC, 0, fetch address and PC after reset.

Ports:
clk  in  1  clock, all state on rising edge.
rst_n  in  1  synchronous active-low reset.
rom_rd  out  1  ROM read strobe.
rom_addr  out  ADDR_W  ROM byte address, valid when rom_rd=1.
rom_data  in  8  ROM read data, valid exactly one cycle after rom_rd.
instr  out  8  opcode byte at FIFO head (risc8_pkg::word).
imm  out  24  head+1 in [7:0], head+2 in [15:8], head+3 in [23:16].
isize  in  2  from control: instruction length minus 1, decoded from instr.
ivalid  out  1  head instruction fully buffered.
iready  in  1  control accepts head instruction.
pc  out  ADDR_W  byte address of instr.
flush  in  1  redirect request.
flush_pc  in  ADDR_W  redirect target.
level  out  $clog2(DEPTH)+1  bytes currently buffered.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset (rst_n=0 at edge) sets:
  - fetch_addr=RESET_PC, pc=RESET_PC, count=0, inflight=0;
  - FIFO storage=0, rd/wr pointers=0.
- Outputs during reset: rom_rd=0, rom_addr=RESET_PC, ivalid=0, instr=0, imm=0, level=0.
- Reset mid-operation discards all buffered bytes and any in-flight read; no write occurs on the cycle after reset.
- rom_addr is the fetch_addr register.
- rom_rd is combinational: rst_n & !flush & (count + inflight < DEPTH).
  - Same-cycle pops are ignored, which is conservative.
- On an edge with rom_rd=1: fetch_addr += 1 (wraps mod 2^ADDR_W), inflight <= 1. Otherwise inflight <= 0.
- On an edge with inflight=1 and no flush: rom_data is written at the wr pointer, count += 1.
- Sustained throughput: 1 byte/cycle.
- ivalid = (count ≥ isize+1) & !flush. It is combinational on isize, so control must decode isize from instr only.
- Pop happens on an edge with ivalid & iready:
  - rd pointer += isize+1 (mod DEPTH), count -= isize+1;
  - pc += isize+1 (wraps).
- Simultaneous push and pop in one cycle: count += 1 - (isize+1).
- instr/imm always show storage at rd, rd+1, rd+2, rd+3 (mod DEPTH).
  - Bytes at positions ≥ count are don't-care to control.
  - Never read unconsumed stale data as valid.
- Flush (edge with flush=1), with priority over pop and push:
  - count=0, rd=wr=0, inflight=0; the in-flight ROM byte is dropped;
  - fetch_addr=flush_pc, pc=flush_pc;
  - rom_rd=0 and ivalid=0 during the flush cycle.
  - The first read of flush_pc issues the next cycle.
- Latency:
  - Reset release to ivalid for a 1-byte instruction: 3 cycles (read issued C1, written C2, ivalid C3).
  - Flush-to-ivalid: same 3 cycles.
  - 4-byte instruction ivalid at C6.
- Full: count + inflight = DEPTH stalls reads. The buffer never overflows and a byte is never dropped outside a flush.
- Empty: ivalid=0; iready is ignored.
- level = count.

Decomposition:
- Add to risc8_pkg:
  - localparam fetch_depth=8;
  - typedef logic [15:0] iaddr;
  - typedef logic [1:0] isize_t with the convention "bytes = isize+1" documented once there.
- One sub-module, risc8_fetch_fifo:
  - byte FIFO with single-byte push;
  - multi-byte pop of 1–4;
  - 4-byte peek window;
  - synchronous clear.
- The top level holds fetch_addr, inflight, pc and the flush logic.

Test Plan:
- Reset release, ROM bytes 00..0F, iready=1, isize=0 → rom_rd C1 addr 0x0000; ivalid C3 with instr=0x00, pc=0x0000; then one instr/cycle, pc incrementing by 1.
- Mixed sizes: ROM program sizes 1,3,4,2 with iready=1 → pc sequence 0,1,4,8; imm of the 4-byte instruction = {b7,b6,b5} from addresses 5..7.
- Backpressure: iready=0 → rom_rd drops after exactly DEPTH=8 reads, level=8, no overflow; iready=1 resumes reads the cycle after the first pop.
- Flush with read in flight: flush_pc=0x0040 while inflight=1 → that byte is discarded, level=0 next cycle; rom_addr=0x0040 issues C+1; ivalid with pc=0x0040 at C+3.
- Flush and pop on the same edge → flush wins; pc=flush_pc, not pc+isize+1; no stale byte appears.
- Wrap: RESET_PC=0xFFFE, 4-byte instruction → rom_addr sequence FFFE, FFFF, 0000, 0001; pc after pop = 0x0002. Also assert rst_n=0 mid-stream → all outputs return to reset values next cycle.

Source files
------------

// File: rtl/risc8_pkg.sv
// risc8_pkg: shared types and constants for the risc8 core
package risc8_pkg;
    typedef logic [7:0] word;
    typedef logic [15:0] iaddr;
    // Instruction length encoding used everywhere: bytes = isize + 1 (1..4).
    typedef logic [1:0] isize_t;
    localparam int fetch_depth = 8;
endpackage

// File: rtl/risc8_fetch_fifo.sv
// risc8_fetch_fifo: byte FIFO with single-byte push, 1-4 byte pop, 4-byte peek window and sync clear
module risc8_fetch_fifo
    import risc8_pkg::*;
#(
    parameter int DEPTH = fetch_depth,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          push_i,
    input  word           din_i,
    input  logic          pop_i,
    input  isize_t        pop_size_i,
    output logic [31:0]   peek_o,
    output logic [CW-1:0] count_o
);
    word           mem_q [DEPTH];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] count_q, count_d, pop_n;
    always_comb begin
        pop_n   = pop_i ? CW'(pop_size_i) + CW'(1) : '0;
        rd_d    = clr_i ? '0 : rd_q + PW'(pop_n);
        wr_d    = clr_i ? '0 : wr_q + PW'(push_i);
        count_d = clr_i ? '0 : count_q + CW'(push_i) - pop_n;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i && !clr_i) mem_q[wr_q] <= din_i;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end
    // Window bytes beyond count are stale; the consumer only trusts isize+1 of them.
    for (genvar k = 0; k < 4; k++) begin : g_peek
        assign peek_o[8*k +: 8] = mem_q[rd_q + PW'(k)];
    end
    assign count_o = count_q;
endmodule

// File: rtl/risc8_fetch.sv
// risc8_fetch: instruction prefetch from byte ROM, presenting opcode plus 3-byte immediate window
// with PC tracking and redirect flush.
module risc8_fetch
    import risc8_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DEPTH = fetch_depth,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  word               rom_data,
    output word               instr,
    output logic [23:0]       imm,
    input  isize_t            isize,
    output logic              ivalid,
    input  logic              iready,
    output logic [ADDR_W-1:0] pc,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    output logic [CW-1:0]     level
);
    localparam int XW = CW + 1;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d, pc_q, pc_d;
    logic              inflight_q, inflight_d, pop;
    logic [31:0]       peek;
    always_comb begin
        // Reserve a slot for the in-flight byte; same-cycle pops are not credited.
        rom_rd       = rst_n && !flush && (XW'(level) + XW'(inflight_q) < XW'(DEPTH));
        ivalid       = !flush && (level >= CW'(isize) + CW'(1));
        pop          = ivalid && iready;
        inflight_d   = rom_rd;
        fetch_addr_d = flush ? flush_pc : fetch_addr_q + ADDR_W'(rom_rd);
        pc_d         = flush ? flush_pc : pc_q + (pop ? ADDR_W'(isize) + ADDR_W'(1) : '0);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_addr_q <= RESET_PC;
            pc_q         <= RESET_PC;
            inflight_q   <= 1'b0;
        end else begin
            fetch_addr_q <= fetch_addr_d;
            pc_q         <= pc_d;
            inflight_q   <= inflight_d;
        end
    end
    risc8_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (flush),
        .push_i    (inflight_q),
        .din_i     (rom_data),
        .pop_i     (pop),
        .pop_size_i(isize),
        .peek_o    (peek),
        .count_o   (level)
    );
    assign rom_addr = fetch_addr_q;
    assign pc       = pc_q;
    assign instr    = peek[7:0];
    assign imm      = peek[31:8];
endmodule

// File: tb/tb_risc8_fetch.sv
// tb_risc8_fetch: directed and randomized checks of risc8_fetch against a program-level model
module tb_risc8_fetch;
    import risc8_pkg::*;
    logic        clk = 1'b0;
    logic        rst_n, rom_rd, ivalid, iready, flush, use_dec;
    logic [15:0] rom_addr, pc, flush_pc;
    logic [7:0]  rom_data, instr;
    logic [23:0] imm;
    logic [1:0]  isize, isize_man;
    logic [3:0]  level;
    logic        rst_nw, rom_rd_w, ivalid_w;
    logic [15:0] rom_addr_w, pc_w;
    logic [7:0]  rom_data_w, instr_w;
    logic [23:0] imm_w;
    logic [3:0]  level_w;
    logic [7:0]  rom [65536];
    int          errs = 0, checks = 0;

    always #5 clk = ~clk;
    assign isize = use_dec ? instr[1:0] : isize_man;

    always @(posedge clk) begin
        rom_data   <= rom_rd ? rom[rom_addr] : 8'($urandom);
        rom_data_w <= rom_rd_w ? rom[rom_addr_w] : 8'($urandom);
    end

    risc8_fetch dut (
        .clk(clk), .rst_n(rst_n), .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
        .instr(instr), .imm(imm), .isize(isize), .ivalid(ivalid), .iready(iready), .pc(pc),
        .flush(flush), .flush_pc(flush_pc), .level(level)
    );
    risc8_fetch #(.RESET_PC(16'hFFFE)) dut_w (
        .clk(clk), .rst_n(rst_nw), .rom_rd(rom_rd_w), .rom_addr(rom_addr_w), .rom_data(rom_data_w),
        .instr(instr_w), .imm(imm_w), .isize(2'd3), .ivalid(ivalid_w), .iready(1'b1), .pc(pc_w),
        .flush(1'b0), .flush_pc(16'h0000), .level(level_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nx();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [23:0] mask_of(input logic [1:0] s);
        return (24'h1 << (8 * s)) - 24'h1;
    endfunction

    initial begin
        logic [15:0] exp_pc, a;
        logic [15:0] pcs [$];
        logic [23:0] imm4, want;
        logic [1:0]  s;
        int          reads, accepted;
        rst_n = 0; rst_nw = 0; iready = 0; flush = 0; flush_pc = 0; use_dec = 0; isize_man = 0;
        for (int i = 0; i < 65536; i++) rom[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) rom[i] = 8'(i);
        repeat (3) nx();
        chk("rst_rom_rd", rom_rd, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_ivalid", ivalid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_imm", imm, 0);
        chk("rst_level", level, 0);
        chk("rst_pc", pc, 0);
        chk("rst_w_addr", rom_addr_w, 16'hFFFE);
        chk("rst_w_rd", rom_rd_w, 0);

        // Sequential 1-byte stream from reset release.
        iready = 1; rst_n = 1; #1;
        chk("c1_rom_rd", rom_rd, 1);
        chk("c1_rom_addr", rom_addr, 0);
        nx();
        chk("c2_ivalid", ivalid, 0);
        chk("c2_rom_addr", rom_addr, 1);
        nx();
        chk("c3_ivalid", ivalid, 1);
        chk("c3_instr", instr, 0);
        chk("c3_pc", pc, 0);
        for (int k = 1; k <= 6; k++) begin
            nx();
            chk("seq_ivalid", ivalid, 1);
            chk("seq_pc", pc, 32'(k));
            chk("seq_instr", instr, 32'(k));
        end

        // Flush while a read is in flight.
        flush = 1; flush_pc = 16'h0040; #1;
        chk("fl_rom_rd", rom_rd, 0);
        chk("fl_ivalid", ivalid, 0);
        nx(); flush = 0; #1;
        chk("fl1_level", level, 0);
        chk("fl1_rom_rd", rom_rd, 1);
        chk("fl1_rom_addr", rom_addr, 16'h0040);
        chk("fl1_ivalid", ivalid, 0);
        nx();
        chk("fl2_ivalid", ivalid, 0);
        chk("fl2_level", level, 0);
        nx();
        chk("fl3_ivalid", ivalid, 1);
        chk("fl3_pc", pc, 16'h0040);
        chk("fl3_instr", instr, rom[16'h0040]);
        nx();
        chk("fl4_pc", pc, 16'h0041);
        nx();
        chk("fp_pre_pc", pc, 16'h0042);
        chk("fp_pre_ivalid", ivalid, 1);

        // Flush and pop requested together: flush wins.
        flush = 1; flush_pc = 16'h0080; #1;
        chk("fp_ivalid", ivalid, 0);
        nx(); flush = 0; #1;
        chk("fp_pc", pc, 16'h0080);
        chk("fp_level", level, 0);
        nx(); nx();
        chk("fp3_ivalid", ivalid, 1);
        chk("fp3_pc", pc, 16'h0080);
        chk("fp3_instr", instr, rom[16'h0080]);
        nx();

        // Reset asserted mid-stream.
        rst_n = 0; nx();
        chk("mr_rom_rd", rom_rd, 0);
        chk("mr_rom_addr", rom_addr, 0);
        chk("mr_ivalid", ivalid, 0);
        chk("mr_instr", instr, 0);
        chk("mr_imm", imm, 0);
        chk("mr_level", level, 0);
        chk("mr_pc", pc, 0);

        // Mixed sizes 1,3,4,2; size is decoded from opcode bits [1:0].
        rom[0] = 8'h00; rom[1] = 8'h12; rom[2] = 8'hA2; rom[3] = 8'hA3;
        rom[4] = 8'h23; rom[5] = 8'hB5; rom[6] = 8'hB6; rom[7] = 8'hB7;
        rom[8] = 8'h31; rom[9] = 8'hC9;
        use_dec = 1; nx();
        rst_n = 1; imm4 = 'x;
        for (int c = 0; c < 20; c++) begin
            nx();
            if (ivalid && iready) begin
                pcs.push_back(pc);
                if (pc == 16'h4) imm4 = imm;
            end
        end
        chk("mix_count_ge4", 32'(pcs.size() >= 4), 1);
        if (pcs.size() >= 4) begin
            chk("mix_pc0", pcs[0], 0);
            chk("mix_pc1", pcs[1], 1);
            chk("mix_pc2", pcs[2], 4);
            chk("mix_pc3", pcs[3], 8);
        end
        chk("mix_imm4", imm4, 24'hB7B6B5);

        // Backpressure: reads stop at DEPTH bytes.
        rst_n = 0; use_dec = 0; isize_man = 0; iready = 0;
        nx(); nx();
        rst_n = 1; #1;
        reads = 0;
        for (int c = 0; c < 14; c++) begin
            if (rom_rd) reads++;
            nx();
        end
        chk("bp_reads", reads, 8);
        chk("bp_level", level, 8);
        chk("bp_rom_rd", rom_rd, 0);
        chk("bp_instr", instr, rom[0]);
        chk("bp_ivalid", ivalid, 1);
        iready = 1; #1;
        chk("bp_pop_cycle_rd", rom_rd, 0);
        nx();
        chk("bp_resume_rd", rom_rd, 1);
        chk("bp_resume_addr", rom_addr, 8);
        chk("bp_resume_pc", pc, 1);
        chk("bp_resume_level", level, 7);
        chk("bp_resume_instr", instr, rom[1]);

        // Randomized run against the program-level model.
        use_dec = 1; flush = 1; flush_pc = 16'h0200; exp_pc = 16'h0200;
        nx();
        accepted = 0;
        for (int c = 0; c < 600; c++) begin
            iready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 39) == 0);
            if (flush) flush_pc = 16'h0200 + 16'($urandom_range(0, 255));
            #1;
            if (flush) begin
                chk("rnd_fl_ivalid", ivalid, 0);
                chk("rnd_fl_rd", rom_rd, 0);
                exp_pc = flush_pc;
            end else if (ivalid) begin
                s = rom[exp_pc][1:0];
                want = {rom[16'(exp_pc + 3)], rom[16'(exp_pc + 2)], rom[16'(exp_pc + 1)]};
                chk("rnd_pc", pc, exp_pc);
                chk("rnd_instr", instr, rom[exp_pc]);
                chk("rnd_imm", imm & mask_of(s), want & mask_of(s));
                if (iready) begin
                    exp_pc = 16'(exp_pc + 16'(s) + 16'd1);
                    accepted++;
                end
            end
            chk("rnd_level_bound", 32'(level <= 4'd8), 1);
            nx();
        end
        flush = 0;
        chk("rnd_progress", 32'(accepted > 100), 1);

        // Address wrap from RESET_PC = 0xFFFE with a 4-byte instruction.
        rst_nw = 1; #1;
        a = 16'hFFFE;
        for (int c = 0; c < 4; c++) begin
            chk("wr_rd", rom_rd_w, 1);
            chk("wr_addr", rom_addr_w, a);
            a = 16'(a + 1);
            nx();
        end
        chk("wr_c5_ivalid", ivalid_w, 0);
        nx();
        chk("wr_c6_ivalid", ivalid_w, 1);
        chk("wr_c6_pc", pc_w, 16'hFFFE);
        chk("wr_c6_instr", instr_w, rom[16'hFFFE]);
        chk("wr_c6_imm", imm_w, {rom[1], rom[0], rom[16'hFFFF]});
        nx();
        chk("wr_c7_pc", pc_w, 16'h0002);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
